// File: rtl/iob_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : iob_sat_add
// Brief    : Combinational signed adder, A_W-bit result, B_W-bit addend
//            sign-extended. Overflow flag always reported; result either
//            wraps (SAT=0) or clamps to the signed range of A_W (SAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module iob_sat_add #(
  parameter int A_W = 32,
  parameter int B_W = 32,
  parameter bit SAT = 1'b0
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [A_W-1:0] sum_o,
  output logic           ovf_o
);

  localparam logic [A_W-1:0] SAT_MAX = {1'b0, {(A_W-1){1'b1}}};
  localparam logic [A_W-1:0] SAT_MIN = {1'b1, {(A_W-1){1'b0}}};

  logic [A_W:0] sum_full;

  // One guard bit above the result: operands are sign-extended to A_W+1 so
  // the guard bit disagreeing with the result MSB is exactly signed overflow.
  always_comb begin
    sum_full = {a_i[A_W-1], a_i} + {{(A_W+1-B_W){b_i[B_W-1]}}, b_i};
    ovf_o    = sum_full[A_W] ^ sum_full[A_W-1];
  end

  generate
    if (SAT) begin : g_sat
      // On overflow the guard bit holds the true sign of the sum.
      always_comb begin
        if (ovf_o) sum_o = sum_full[A_W] ? SAT_MIN : SAT_MAX;
        else       sum_o = sum_full[A_W-1:0];
      end
    end else begin : g_wrap
      // Two's-complement wrap simply drops the guard bit.
      always_comb sum_o = sum_full[A_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/iob_integ.sv
`default_nettype none
// ============================================================================
// Module   : iob_integ
// Brief    : Signed discrete integrator rebuilding an absolute signal from a
//            delta stream. Valid/ready on both sides, single registered
//            output stage (the accumulator itself), sticky overflow flag,
//            sync clear / load, clock enable, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module iob_integ #(
  parameter int             DATA_W  = 32,
  parameter int             ACC_W   = 32,
  parameter logic [ACC_W-1:0] RST_VAL = '0,
  parameter bit             SAT     = 1'b0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic              ld_i,
  input  logic [ACC_W-1:0]  ld_val_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [ACC_W-1:0]  data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;
  logic             accept;

  iob_sat_add #(
    .A_W (ACC_W),
    .B_W (DATA_W),
    .SAT (SAT)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (data_i),
    .sum_o (sum),
    .ovf_o (sum_ovf)
  );

  // Input side may take a sample only when the output slot is free or being
  // drained this cycle; clear/load steal the cycle so no sample is lost.
  always_comb begin
    ready_o = cke_i & ~rst_i & ~ld_i & (~valid_q | ready_i);
    accept  = valid_i & ready_o;
  end

  // Next-state selection: clear > load > accept > output drain.
  always_comb begin
    acc_d   = acc_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (cke_i) begin
      if (rst_i) begin
        acc_d   = RST_VAL;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
      end else if (ld_i) begin
        acc_d   = ld_val_i;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
      end else if (accept) begin
        acc_d   = sum;
        valid_d = 1'b1;
        ovf_d   = ovf_q | sum_ovf;
      end else if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers; async reset drops any pending output.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      acc_q   <= RST_VAL;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // The accumulator doubles as the output register.
  always_comb begin
    data_o  = acc_q;
    valid_o = valid_q;
    ovf_o   = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_integ.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_integ
// Brief    : Self-checking bench for iob_integ (8-bit). A wrapping and a
//            saturating instance share stimulus; an integer-arithmetic model
//            predicts ready/data/valid/overflow for both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_integ;

  logic       clk;
  logic       cke, arst_n, rst, ld, vin, rdy_in;
  logic [7:0] ldv, din;
  logic       ready0, valid0, ovf0;
  logic       ready1, valid1, ovf1;
  logic [7:0] data0, data1;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state (plain signed integers)
  int m_acc0, m_acc1;
  bit m_ovf0, m_ovf1, m_vld;

  iob_integ #(.DATA_W(8), .ACC_W(8), .RST_VAL(8'h00), .SAT(1'b0)) u_wrap (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst), .ld_i(ld),
    .ld_val_i(ldv), .data_i(din), .valid_i(vin), .ready_o(ready0),
    .data_o(data0), .valid_o(valid0), .ready_i(rdy_in), .ovf_o(ovf0)
  );

  iob_integ #(.DATA_W(8), .ACC_W(8), .RST_VAL(8'h00), .SAT(1'b1)) u_sat (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst), .ld_i(ld),
    .ld_val_i(ldv), .data_i(din), .valid_i(vin), .ready_o(ready1),
    .data_o(data1), .valid_o(valid1), .ready_i(rdy_in), .ovf_o(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to8(input int v);
    logic [31:0] t;
    t = v;
    return t[7:0];
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".data_w"}, {24'h0, data0}, {24'h0, to8(m_acc0)});
    check({tag, ".data_s"}, {24'h0, data1}, {24'h0, to8(m_acc1)});
    check({tag, ".valid_w"}, {31'h0, valid0}, {31'h0, m_vld});
    check({tag, ".valid_s"}, {31'h0, valid1}, {31'h0, m_vld});
    check({tag, ".ovf_w"}, {31'h0, ovf0}, {31'h0, m_ovf0});
    check({tag, ".ovf_s"}, {31'h0, ovf1}, {31'h0, m_ovf1});
  endtask

  // One clock: drive at negedge, check ready before the edge, update model at
  // the edge, check registered outputs just after it. Returns at negedge.
  task automatic cycle(input logic c, input logic r, input logic l,
                       input logic [7:0] lv, input logic [7:0] d,
                       input logic v, input logic ri, input string tag);
    bit exp_rdy;
    int sd, s0, s1;
    cke = c; rst = r; ld = l; ldv = lv; din = d; vin = v; rdy_in = ri;
    #1;
    exp_rdy = c && !r && !l && (!m_vld || ri);
    check({tag, ".rdy_w"}, {31'h0, ready0}, {31'h0, exp_rdy});
    check({tag, ".rdy_s"}, {31'h0, ready1}, {31'h0, exp_rdy});
    @(posedge clk);
    #1;
    if (c) begin
      if (r) begin
        m_acc0 = 0; m_acc1 = 0; m_ovf0 = 0; m_ovf1 = 0; m_vld = 0;
      end else if (l) begin
        m_acc0 = int'($signed(lv)); m_acc1 = m_acc0;
        m_ovf0 = 0; m_ovf1 = 0; m_vld = 0;
      end else if (v && exp_rdy) begin
        sd = int'($signed(d));
        s0 = m_acc0 + sd;
        s1 = m_acc1 + sd;
        if (s0 > 127 || s0 < -128) m_ovf0 = 1;
        if (s1 > 127 || s1 < -128) m_ovf1 = 1;
        m_acc0 = ((s0 + 128) % 256 + 256) % 256 - 128;
        m_acc1 = (s1 > 127) ? 127 : (s1 < -128) ? -128 : s1;
        m_vld  = 1;
      end else if (m_vld && ri) begin
        m_vld = 0;
      end
    end
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic areset(input string tag);
    arst_n = 1'b0;
    #1;
    m_acc0 = 0; m_acc1 = 0; m_ovf0 = 0; m_ovf1 = 0; m_vld = 0;
    check_outs(tag);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  logic [7:0] rt_seq [5];
  logic [7:0] prev, delta;

  initial begin
    cke = 1'b1; arst_n = 1'b1; rst = 1'b0; ld = 1'b0; ldv = '0;
    din = '0; vin = 1'b0; rdy_in = 1'b1;
    m_acc0 = 0; m_acc1 = 0; m_ovf0 = 0; m_ovf1 = 0; m_vld = 0;
    @(negedge clk);
    areset("reset");
    cycle(1, 0, 0, 8'h00, 8'h00, 0, 1, "post_reset");

    // accumulate 5, 3, -2 back to back
    cycle(1, 0, 0, 8'h00, 8'h05, 1, 1, "acc5");
    check("acc5.abs", {24'h0, data0}, 32'h05);
    cycle(1, 0, 0, 8'h00, 8'h03, 1, 1, "acc8");
    check("acc8.abs", {24'h0, data0}, 32'h08);
    cycle(1, 0, 0, 8'h00, 8'hFE, 1, 1, "acc6");
    check("acc6.abs", {24'h0, data0}, 32'h06);
    cycle(1, 0, 0, 8'h00, 8'h00, 0, 1, "drain");

    // positive overflow: wrap vs saturate
    cycle(1, 0, 1, 8'd120, 8'h00, 1, 1, "ld120");
    cycle(1, 0, 0, 8'h00, 8'd10, 1, 1, "ovf_pos");
    check("ovf_pos.wrap", {24'h0, data0}, 32'h82);
    check("ovf_pos.sat", {24'h0, data1}, 32'h7F);
    cycle(1, 0, 0, 8'h00, 8'd1, 1, 1, "ovf_sticky");
    check("ovf_sticky.wrap", {24'h0, data0}, 32'h83);
    cycle(1, 1, 0, 8'h00, 8'h00, 1, 1, "sync_clr");
    // negative overflow
    cycle(1, 0, 1, 8'h88, 8'h00, 0, 1, "ld_m120");
    cycle(1, 0, 0, 8'h00, 8'hF6, 1, 1, "ovf_neg");
    check("ovf_neg.sat", {24'h0, data1}, 32'h80);
    cycle(1, 1, 0, 8'h00, 8'h00, 0, 1, "clr2");

    // backpressure
    cycle(1, 0, 0, 8'h00, 8'h04, 1, 0, "bp_first");
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h00, 8'h07, 1, 0, "bp_hold");
    cycle(1, 0, 0, 8'h00, 8'h07, 1, 1, "bp_release");
    check("bp_release.abs", {24'h0, data0}, 32'h0B);
    cycle(1, 0, 0, 8'h00, 8'h00, 0, 1, "bp_drain");

    // clock enable low freezes everything, even clear and load
    cycle(1, 0, 0, 8'h00, 8'h02, 1, 0, "cke_pre");
    cycle(0, 1, 0, 8'h00, 8'h05, 1, 1, "cke_off_rst");
    cycle(0, 0, 1, 8'h33, 8'h05, 1, 1, "cke_off_ld");

    // round trip through a first-difference stage
    cycle(1, 1, 0, 8'h00, 8'h00, 0, 1, "rt_clr");
    rt_seq[0] = 8'h00; rt_seq[1] = 8'd10; rt_seq[2] = 8'd25;
    rt_seq[3] = 8'd7;  rt_seq[4] = 8'hF0;
    prev = 8'h00;
    for (int i = 0; i < 5; i++) begin
      delta = rt_seq[i] - prev;
      prev  = rt_seq[i];
      cycle(1, 0, 0, 8'h00, delta, 1, 1, "rt");
      check("rt.abs", {24'h0, data0}, {24'h0, rt_seq[i]});
    end

    // randomized traffic, with one async reset in the middle
    for (int i = 0; i < 500; i++) begin
      if (i == 250) areset("rand_arst");
      cycle(($urandom % 10) != 0, ($urandom % 25) == 0, ($urandom % 15) == 0,
            8'($urandom), 8'($urandom), ($urandom % 4) != 0,
            ($urandom % 3) != 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
